// File: rtl/peribus_hub.sv
// Peripheral hub: decodes a host word address onto NUM_SLOTS slots plus four
// interrupt control registers. Define PERIBUS_IRQ_LATCH_EN for edge-latched PENDING.
module peribus_hub #(
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned SLOT_WORDS = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [DATA_WIDTH-1:0]             write_data,
  input  logic                              write_enable,
  input  logic                              read_enable,
  output logic [DATA_WIDTH-1:0]             read_data,
  output logic                              read_valid,
  output logic                              error,
  output logic                              irq,
  output logic [NUM_SLOTS-1:0]              slot_chipselect,
  output logic [$clog2(SLOT_WORDS)-1:0]     slot_addr,
  output logic [DATA_WIDTH-1:0]             slot_write_data,
  output logic                              slot_write_en,
  output logic                              slot_read_en,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0]   slot_read_data,
  input  logic [NUM_SLOTS-1:0]              slot_irq
);

  localparam int unsigned SLOT_AW = $clog2(SLOT_WORDS);
  localparam int unsigned IDX_W   = ADDR_WIDTH - SLOT_AW;
  localparam logic [ADDR_WIDTH-1:0] CTRL_BASE = ADDR_WIDTH'(NUM_SLOTS * SLOT_WORDS);

  logic                  in_slot, in_ctrl, collide, rejected, acc_rd, acc_wr;
  logic [ADDR_WIDTH-1:0] ctrl_off_full;
  logic [1:0]            ctrl_off;
  logic [IDX_W-1:0]      slot_idx;

  logic [NUM_SLOTS-1:0]  pending_q, pending_d, enable_q, enable_d, active;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d, slot_sel, ctrl_rd, vector;
  logic                  read_valid_q, read_valid_d, error_q, error_d, irq_q, irq_d;
  logic                  found;

  // Address decode and strobe gating
  always_comb begin
    in_slot       = addr < CTRL_BASE;
    ctrl_off_full = addr - CTRL_BASE;
    in_ctrl       = !in_slot && (ctrl_off_full < ADDR_WIDTH'(4));
    ctrl_off      = ctrl_off_full[1:0];
    slot_idx      = addr[ADDR_WIDTH-1:SLOT_AW];
    slot_chipselect = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      slot_chipselect[k] = in_slot && (slot_idx == IDX_W'(k));
    end
    collide  = write_enable && read_enable;
    rejected = (write_enable || read_enable) && (collide || !(in_slot || in_ctrl));
    acc_rd   = read_enable  && !collide && (in_slot || in_ctrl);
    acc_wr   = write_enable && !collide && (in_slot || in_ctrl);
  end

  assign slot_addr       = addr[SLOT_AW-1:0];
  assign slot_write_data = write_data;
  assign slot_write_en   = acc_wr && in_slot && !reset;
  assign slot_read_en    = acc_rd && in_slot && !reset;

  // Read mux and lowest-index vector
  always_comb begin
    active = pending_q & enable_q;
    vector = '1;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (!found && active[k]) begin
        vector = DATA_WIDTH'(k);
        found  = 1'b1;
      end
    end
    slot_sel = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (slot_chipselect[k]) slot_sel = slot_read_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    case (ctrl_off)
      2'd0:    ctrl_rd = DATA_WIDTH'(pending_q);
      2'd1:    ctrl_rd = DATA_WIDTH'(enable_q);
      2'd2:    ctrl_rd = '0;
      default: ctrl_rd = vector;
    endcase
  end

  always_comb begin
    enable_d = enable_q;
    if (acc_wr && in_ctrl && ctrl_off == 2'd1) enable_d = write_data[NUM_SLOTS-1:0];
    read_data_d = read_data_q;
    if (acc_rd)        read_data_d = in_slot ? slot_sel : ctrl_rd;
    else if (rejected) read_data_d = '0;
    read_valid_d = acc_rd;
    error_d      = rejected;
    irq_d        = |active;
  end

`ifdef PERIBUS_IRQ_LATCH_EN
  logic [NUM_SLOTS-1:0] irq_hist_q, irq_hist_d, clear_mask;

  // A fresh rising edge overrides a simultaneous CLEAR of the same bit
  always_comb begin
    clear_mask = '0;
    if (acc_wr && in_ctrl && ctrl_off == 2'd2) clear_mask = write_data[NUM_SLOTS-1:0];
    pending_d  = (pending_q & ~clear_mask) | (slot_irq & ~irq_hist_q);
    irq_hist_d = slot_irq;
  end

  always_ff @(posedge clock) begin
    if (reset) irq_hist_q <= '0;
    else       irq_hist_q <= irq_hist_d;
  end
`else
  always_comb begin
    pending_d = slot_irq;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q    <= '0;
      enable_q     <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      error_q      <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      error_q      <= error_d;
      irq_q        <= irq_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign error      = error_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_peribus_hub.sv
// Directed bench for peribus_hub at default parameters; interrupt expectations
// follow PERIBUS_IRQ_LATCH_EN when it is defined.
module tb_peribus_hub;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   addr;
  logic [15:0]  write_data;
  logic         write_enable, read_enable;
  logic [15:0]  read_data;
  logic         read_valid, error, irq;
  logic [7:0]   slot_chipselect;
  logic [1:0]   slot_addr;
  logic [15:0]  slot_write_data;
  logic         slot_write_en, slot_read_en;
  logic [127:0] slot_read_data;
  logic [7:0]   slot_irq;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  peribus_hub #(.NUM_SLOTS(8), .SLOT_WORDS(4), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clock(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .write_enable(write_enable), .read_enable(read_enable),
    .read_data(read_data), .read_valid(read_valid), .error(error), .irq(irq),
    .slot_chipselect(slot_chipselect), .slot_addr(slot_addr),
    .slot_write_data(slot_write_data), .slot_write_en(slot_write_en),
    .slot_read_en(slot_read_en), .slot_read_data(slot_read_data),
    .slot_irq(slot_irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [15:0] d, input logic w, input logic r);
    @(negedge clk);
    addr = a; write_data = d; write_enable = w; read_enable = r;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
    drive(a, 16'h0, 1'b0, 1'b1);
    tick();
    check_eq(tag, {read_valid, read_data}, {1'b1, exp});
  endtask

  initial begin
    reset = 1'b1; addr = '0; write_data = '0; write_enable = 0; read_enable = 0;
    slot_irq = '0;
    for (int k = 0; k < 8; k++) slot_read_data[k*16 +: 16] = 16'h1000 + 16'(k);
    slot_read_data[2*16 +: 16] = 16'hBEEF;
    tick(); tick();
    check_eq("rst_read_data", read_data, 16'h0);
    check_eq("rst_flags", {read_valid, error, irq}, 3'b000);
    @(negedge clk); reset = 1'b0;

    // slot read, latency 1
    drive(8'h09, 16'h0, 0, 1);
    check_eq("rd_cs", slot_chipselect, 8'h04);
    check_eq("rd_slot_addr", slot_addr, 2'd1);
    check_eq("rd_strobes", {slot_read_en, slot_write_en}, 2'b10);
    tick();
    check_eq("rd_data", read_data, 16'hBEEF);
    check_eq("rd_valid", {read_valid, error}, 2'b10);
    drive(8'h00, 16'h0, 0, 0);
    tick();
    check_eq("rd_hold", {read_valid, read_data}, {1'b0, 16'hBEEF});

    // slot write
    drive(8'h1F, 16'h1234, 1, 0);
    check_eq("wr_cs", slot_chipselect, 8'h80);
    check_eq("wr_strobes", {slot_write_en, slot_read_en}, 2'b10);
    check_eq("wr_slot_addr", slot_addr, 2'd3);
    check_eq("wr_data", slot_write_data, 16'h1234);
    tick();
    check_eq("wr_no_err", {error, read_valid}, 2'b00);

    // rejected accesses
    drive(8'h24, 16'h0, 0, 1);
    check_eq("unmap_cs", slot_chipselect, 8'h00);
    check_eq("unmap_strobe", {slot_read_en, slot_write_en}, 2'b00);
    tick();
    check_eq("unmap_err", {error, read_valid, read_data}, {2'b10, 16'h0});
    rd_check("slot0_rd", 8'h00, 16'h1000);
    drive(8'h00, 16'h5555, 1, 1);
    check_eq("coll_strobe", {slot_read_en, slot_write_en}, 2'b00);
    tick();
    check_eq("coll_err", {error, read_valid, read_data}, {2'b10, 16'h0});
    drive(8'h00, 16'h0, 0, 0);
    tick();
    check_eq("err_pulse_end", error, 1'b0);

    // control registers
    drive(8'h21, 16'hFF0A, 1, 0);
    check_eq("ctrl_cs", slot_chipselect, 8'h00);
    tick();
    rd_check("enable_rd", 8'h21, 16'h000A);
    drive(8'h20, 16'hFFFF, 1, 0);
    tick();
    check_eq("ro_wr_no_err", error, 1'b0);
    rd_check("pending_ro", 8'h20, 16'h0000);
    rd_check("vector_none", 8'h23, 16'hFFFF);

`ifdef PERIBUS_IRQ_LATCH_EN
    drive(8'h00, 16'h0, 0, 0); slot_irq = 8'h08;
    tick();
    check_eq("irq_lag", irq, 1'b0);
    drive(8'h00, 16'h0, 0, 0); slot_irq = 8'h00;
    tick();
    check_eq("irq_set", irq, 1'b1);
    rd_check("pending_latched", 8'h20, 16'h0008);
    rd_check("vector_3", 8'h23, 16'h0003);
    drive(8'h22, 16'h0008, 1, 0);
    tick();
    check_eq("clr_irq_t1", {irq, error}, 2'b10);
    drive(8'h00, 16'h0, 0, 0);
    tick();
    check_eq("clr_irq_t2", irq, 1'b0);
    drive(8'h22, 16'h0002, 1, 0); slot_irq = 8'h02;
    tick();
    rd_check("set_wins", 8'h20, 16'h0002);
    check_eq("set_wins_irq", irq, 1'b1);
`else
    drive(8'h00, 16'h0, 0, 0); slot_irq = 8'h08;
    tick();
    check_eq("irq_lag", irq, 1'b0);
    drive(8'h00, 16'h0, 0, 0);
    tick();
    check_eq("irq_set", irq, 1'b1);
    rd_check("pending_level", 8'h20, 16'h0008);
    rd_check("vector_3", 8'h23, 16'h0003);
    rd_check("clear_reads_0", 8'h22, 16'h0000);
    drive(8'h22, 16'h0008, 1, 0);
    tick();
    check_eq("clr_no_err", error, 1'b0);
    rd_check("clr_no_effect", 8'h20, 16'h0008);
    drive(8'h00, 16'h0, 0, 0); slot_irq = 8'h00;
    tick();
    check_eq("irq_drop_t1", irq, 1'b1);
    drive(8'h00, 16'h0, 0, 0);
    tick();
    check_eq("irq_drop_t2", irq, 1'b0);
    drive(8'h00, 16'h0, 0, 0); slot_irq = 8'h02;
    tick(); tick();
    check_eq("irq_slot1", irq, 1'b1);
`endif

    // reset with irq high and a read in flight
    drive(8'h09, 16'h0, 0, 1);
    reset = 1'b1;
    #1;
    check_eq("rst_strobe", {slot_read_en, slot_write_en}, 2'b00);
    tick();
    check_eq("rst_inflight", {irq, read_valid, error}, 3'b000);
    check_eq("rst_rdata", read_data, 16'h0);
    drive(8'h00, 16'h0, 0, 0);
    reset = 1'b0;
    tick();
    rd_check("rst_enable", 8'h21, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
